// File: rtl/addsub_if.sv
// Operand issue / result retire bundle for the pipelined add/subtract unit.
// The master drives operations and flag writes; the slave returns ready, result and flags.
interface addsub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [1:0]       op;
   logic             s;
   logic             flush;
   logic             flag_we;
   logic [3:0]       flag_in;
   logic [WIDTH-1:0] result;
   logic             out_valid;
   logic [3:0]       flag;

   modport master (
      output in_valid, in1, in2, op, s, flush, flag_we, flag_in,
      input  in_ready, result, out_valid, flag
   );

   modport slave (
      input  in_valid, in1, in2, op, s, flush, flag_we, flag_in,
      output in_ready, result, out_valid, flag
   );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: one CHUNK-bit carry slice per stage, NZCV flag register,
// ADC/SBC carry-in from the flags with an interlock against in-flight flag writers.
module addsub_pipe #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input logic       clk,
   input logic       rst_n,
   addsub_if.slave   bus
);
   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;

   logic [STAGES-1:0] vld_q, vld_d;
   logic [STAGES-1:0] s_q, s_d;
   logic [STAGES-1:0] cy_q, cy_d;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic [WIDTH-1:0]  result_q, result_d;
   logic              out_valid_q, out_valid_d;
   logic [3:0]        flag_q, flag_d;

   logic [WIDTH-1:0]  sum_nx [STAGES];
   logic [STAGES-1:0] cy_out;
   logic [CHUNK:0]    part;
   logic [WIDTH-1:0]  res;
   logic              accept;
   logic              retire;

   // ADC/SBC must not read the carry while any flag-setting op is still in flight.
   assign bus.in_ready  = ~bus.flush & ~(bus.op[0] & (|(vld_q & s_q)));
   assign bus.result    = result_q;
   assign bus.out_valid = out_valid_q;
   assign bus.flag      = flag_q;

   always_comb begin
      part   = '0;
      cy_out = '0;
      for (int i = 0; i < STAGES; i++) begin
         part      = {1'b0, a_q[i][i*CHUNK +: CHUNK]} + {1'b0, b_q[i][i*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, cy_q[i]};
         sum_nx[i] = sum_q[i];
         sum_nx[i][i*CHUNK +: CHUNK] = part[CHUNK-1:0];
         cy_out[i] = part[CHUNK];
      end
   end

   always_comb begin
      accept = bus.in_valid & bus.in_ready;
      retire = vld_q[LAST] & ~bus.flush;

      // Stage 0 captures raw operands; B is pre-inverted for SUB/SBC.
      vld_d[0] = accept;
      s_d[0]   = bus.s;
      a_d[0]   = bus.in1;
      b_d[0]   = bus.op[1] ? ~bus.in2 : bus.in2;
      sum_d[0] = '0;
      cy_d[0]  = bus.op[0] ? flag_q[1] : bus.op[1];
      for (int i = 1; i < STAGES; i++) begin
         vld_d[i] = vld_q[i-1] & ~bus.flush;
         s_d[i]   = s_q[i-1];
         a_d[i]   = a_q[i-1];
         b_d[i]   = b_q[i-1];
         sum_d[i] = sum_nx[i-1];
         cy_d[i]  = cy_out[i-1];
      end

      res         = sum_nx[LAST];
      result_d    = result_q;
      out_valid_d = retire;
      flag_d      = flag_q;
      if (retire) begin
         result_d = res;
         if (s_q[LAST]) begin
            flag_d = {res[WIDTH-1], (res == '0), cy_out[LAST],
                      (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
                      (res[WIDTH-1] != a_q[LAST][WIDTH-1])};
         end
      end
      if (bus.flag_we) begin
         flag_d = bus.flag_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q       <= '0;
         s_q         <= '0;
         cy_q        <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         flag_q      <= 4'b0000;
         for (int i = 0; i < STAGES; i++) begin
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            sum_q[i] <= '0;
         end
      end else begin
         vld_q       <= vld_d;
         s_q         <= s_d;
         cy_q        <= cy_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         flag_q      <= flag_d;
         for (int i = 0; i < STAGES; i++) begin
            a_q[i]   <= a_d[i];
            b_q[i]   <= b_d[i];
            sum_q[i] <= sum_d[i];
         end
      end
   end
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: issue side queues expected retirements,
// an independent monitor pops and compares on every Out_Valid pulse.
module tb_addsub_pipe;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_ADC = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_SBC = 2'b11;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  flg;
      logic [31:0] ret_edge;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   addsub_if #(.WIDTH(32)) bus ();

   addsub_pipe #(.WIDTH(32), .CHUNK(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   pulses = 0;
   int   stalls;
   int   p0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
         pulses++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_retire actual=%h required=none", bus.result);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result", bus.result, mon_e.res);
            chk("flag", {28'd0, bus.flag}, {28'd0, mon_e.flg});
            chk("latency_edge", cyc, mon_e.ret_edge);
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic s, input logic expect_it, input logic [31:0] er,
                        input logic [3:0] ef, output int stl);
      bit acc;
      acc          = 1'b0;
      stl          = 0;
      bus.in_valid = 1'b1;
      bus.in1      = a;
      bus.in2      = b;
      bus.op       = op;
      bus.s        = s;
      for (int n = 0; n < 20 && !acc; n++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         if (!acc) stl++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=stalled required=accept");
      end else if (expect_it) begin
         exp_q.push_back('{er, ef, 32'(cyc + 4)});
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in1      = '0;
      bus.in2      = '0;
      bus.op       = OP_ADD;
      bus.s        = 1'b0;
      bus.flush    = 1'b0;
      bus.flag_we  = 1'b0;
      bus.flag_in  = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_result", bus.result, 32'd0);
      chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset_flag", {28'd0, bus.flag}, 32'd0);
      chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // back-to-back adds, then overflow and borrow cases
      issue(32'd2, 32'd3, OP_ADD, 1'b1, 1'b1, 32'd5, 4'b0000, stalls);
      issue(32'hFFFF_FFFA, 32'hFFFF_FFFE, OP_ADD, 1'b1, 1'b1, 32'hFFFF_FFF8, 4'b1010, stalls);
      chk("add_no_stall", stalls, 32'd0);
      issue(32'h7FFF_FFFF, 32'd1, OP_ADD, 1'b1, 1'b1, 32'h8000_0000, 4'b1001, stalls);
      issue(32'd1, 32'hFFFF_FFFD, OP_SUB, 1'b1, 1'b1, 32'd4, 4'b0000, stalls);
      repeat (6) @(posedge clk);
      #1;

      // flag-hazard interlock
      issue(32'd4, 32'd4, OP_SUB, 1'b1, 1'b1, 32'd0, 4'b0110, stalls);
      issue(32'hFFFF_FFFF, 32'd0, OP_ADC, 1'b1, 1'b1, 32'd0, 4'b0110, stalls);
      chk("adc_stalls", stalls, 32'd4);
      issue(32'd1, 32'd1, OP_ADD, 1'b0, 1'b1, 32'd2, 4'b0110, stalls);
      issue(32'd5, 32'd3, OP_SBC, 1'b1, 1'b1, 32'd2, 4'b0010, stalls);
      chk("sbc_stalls", stalls, 32'd3);
      repeat (6) @(posedge clk);
      #1;

      // flush with three ops in flight; the op presented during flush is refused
      issue(32'd10, 32'd10, OP_ADD, 1'b1, 1'b0, 32'd0, 4'b0000, stalls);
      issue(32'd10, 32'd11, OP_ADD, 1'b1, 1'b0, 32'd0, 4'b0000, stalls);
      issue(32'd10, 32'd12, OP_ADD, 1'b1, 1'b0, 32'd0, 4'b0000, stalls);
      p0           = pulses;
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.op       = OP_ADD;
      bus.s        = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("flush_pulses", pulses - p0, 32'd0);
      chk("flush_flag", {28'd0, bus.flag}, {28'd0, 4'b0010});
      issue(32'd7, 32'd8, OP_ADD, 1'b0, 1'b1, 32'd15, 4'b0010, stalls);
      repeat (6) @(posedge clk);
      #1;

      // direct flag write beats a retiring S=1 op
      issue(32'd2, 32'd3, OP_ADD, 1'b1, 1'b1, 32'd5, 4'b0001, stalls);
      repeat (3) @(posedge clk);
      #1;
      bus.flag_we = 1'b1;
      bus.flag_in = 4'b0001;
      @(posedge clk);
      #1;
      bus.flag_we = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // asynchronous reset with two ops in flight
      issue(32'd1, 32'd1, OP_ADD, 1'b1, 1'b0, 32'd0, 4'b0000, stalls);
      issue(32'd1, 32'd2, OP_ADD, 1'b1, 1'b0, 32'd0, 4'b0000, stalls);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_result", bus.result, 32'd0);
      chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("async_rst_flag", {28'd0, bus.flag}, 32'd0);
      #3;
      rst_n = 1'b1;
      p0    = pulses;
      repeat (8) @(posedge clk);
      #1;
      chk("post_rst_pulses", pulses - p0, 32'd0);
      chk("post_rst_flag", {28'd0, bus.flag}, 32'd0);

      issue(32'hFFFF_FFFF, 32'd1, OP_ADD, 1'b1, 1'b1, 32'd0, 4'b0110, stalls);
      repeat (6) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined integer add/subtract unit. Successor to the single-cycle combinational adder.
- Carry chain is split into CHUNK-bit slices, with one slice per pipeline stage.
- Holds an architectural NZCV flag register, supports ADC/SBC (carry-in from that register) and enforces a flag-hazard interlock on issue.
- Sits in the ALU datapath between operand issue and writeback.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per stage; STAGES = WIDTH/CHUNK (latency).

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- In_Valid  input  1  operation presented this cycle.
- In_Ready  output  1  unit accepts the operation this cycle (accept = In_Valid & In_Ready).
- In1  input  WIDTH  operand A.
- In2  input  WIDTH  operand B.
- Op  input  2  00 ADD, 01 ADC, 10 SUB, 11 SBC.
- S  input  1  update flag register when this op retires.
- Flush  input  1  discard all in-flight ops.
- Flag_We  input  1  direct write of flag register.
- Flag_In  input  4  value for direct write, [3]=N [2]=Z [1]=C [0]=V.
- Result  output  WIDTH  retired result.
- Out_Valid  output  1  Result valid this cycle (single-cycle pulse per op, no backpressure).
- Flag  output  4  current flag register {N,Z,C,V}.

Behaviour:
- Reset: Result=0, Out_Valid=0, Flag=4'b0000, all stage valid bits 0, In_Ready=1. Reset asserted mid-operation drops every in-flight op; nothing retires.
- Arithmetic:
  - ADD: In1+In2+0.
  - ADC: In1+In2+Flag[1].
  - SUB: In1+~In2+1.
  - SBC: In1+~In2+Flag[1].
  - Carry-in is sampled from Flag at the accept edge.
- Pipeline: stage i adds bits [i*CHUNK +: CHUNK] and passes its carry to stage i+1. Not-yet-added high operand bits and already-summed low bits are carried forward with the op.
- Latency: an op accepted at edge k registers Result, asserts Out_Valid, and (if S=1) updates Flag, all at edge k+STAGES. Throughput is 1 op/cycle when not interlocked.
- Flags, computed on the full result:
  - N = Result[WIDTH-1].
  - Z = (Result==0).
  - C = carry out of the MSB (for SUB/SBC, C=1 means no borrow).
  - V = signed overflow: sign(A)==sign(B') and sign(Result)!=sign(A), where B' is In2 for ADD/ADC and ~In2 for SUB/SBC.
- S=0 ops never modify Flag.
- Interlock:
  - In_Ready = 0 when the presented Op is ADC/SBC and any in-flight stage holds an op with S=1. Otherwise In_Ready = 1.
  - An op counts as in flight from the edge after acceptance through the edge at which it retires.
  - The first ADC/SBC accept is therefore at edge k+STAGES+1 and sees the updated flag.
  - ADD/SUB never stall.
- Flush: at the edge where Flush=1, all stage valid bits clear and Out_Valid is 0 for the following cycle. Flag is not modified by flushed ops. An op presented with Flush=1 is not accepted (In_Ready=0 while Flush=1).
- Flag_We: writes Flag_In at the edge. If a retiring S=1 op updates Flag at the same edge, Flag_We wins. Flag_We does not clear the interlock; in-flight S ops still block ADC/SBC.
- Out_Valid is deasserted in any cycle without a retiring op. Result holds its last retired value.

Test Plan (WIDTH=32, CHUNK=8, STAGES=4):
- ADD 2+3, S=1 accepted at edge k -> Out_Valid after edge k+4, Result=5, Flag=0000. Back-to-back ADD -6 + -2, S=1 at edge k+1 -> Result=0xFFFFFFF8, Flag=1010.
- ADD 0x7FFFFFFF+1, S=1 -> Result=0x80000000, Flag=1001. SUB 1-0xFFFFFFFD, S=1 -> Result=4, Flag=0000 (borrow, C=0).
- SUB 4-4, S=1 accepted at edge k, then ADC 0xFFFFFFFF+0 presented from cycle k+1:
  - In_Ready=0 for 4 cycles.
  - ADC accepted at edge k+5 with C=1.
  - ADC result 0 at edge k+9; Flag=0110 if S=1.
- Three ops in flight, Flush=1 for one cycle -> no Out_Valid pulses for those ops, Flag unchanged, next ADD retires normally 4 cycles after accept.
- Flag_We=1, Flag_In=0001 on the same edge an S=1 ADD (result 5) retires -> Flag=0001, Result=5, Out_Valid=1.
- Rst_n pulsed low asynchronously mid-pipeline with 2 ops in flight -> outputs 0 immediately, no retirement after release, Flag=0000.
